// File: rtl/des_decrypt_iter_pkg.sv
// Shared DES constants: permutation tables, S-box contents, reverse key-rotation schedule,
// engine state encoding and the permutation helpers used by the decryption datapath.
package des_pkg;

    localparam int BLK_W  = 64;
    localparam int HALF_W = 32;
    localparam int SUBK_W = 48;
    localparam int CD_W   = 28;

    typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_t;

    // Tables use FIPS-46 numbering: entry value n selects input bit n, bit 1 being the MSB.
    localparam int IP_T [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                                 62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                                 57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                                 61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                                 38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                                 36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                                 34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
    localparam int E_T [48]  = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
                                 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23,
                                 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    localparam int P_T [32]  = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                                 2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                                  10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                                  63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                                  14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    localparam int PC2_T [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4,
                                  26, 8, 16, 7, 27, 20, 13, 2, 41, 52, 31, 37, 47, 55, 30, 40,
                                  51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Right-rotation applied after round i+1 (encrypt shifts 16 down to 2); last slot unused.
    localparam logic [1:0] DEC_ROT [16] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
                                            2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0};

    // S-box n: 64 nibbles, row-major (row = b1b6, column = b2..b5), first entry in the MSBs.
    localparam logic [255:0] SBOX_T [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[63-i] = x[64-IP_T[i]];
        return r;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[63-i] = x[64-FP_T[i]];
        return r;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] x);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[47-i] = x[32-E_T[i]];
        return r;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[31-i] = x[32-P_T[i]];
        return r;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] k);
        logic [55:0] r;
        for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1_T[i]];
        return r;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] cd);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_T[i]];
        return r;
    endfunction

    function automatic logic [3:0] sbox(input int n, input logic [5:0] b);
        int idx;
        idx = {26'd0, b[5], b[0], b[4:1]};
        return SBOX_T[n][255-4*idx -: 4];
    endfunction

    function automatic logic [27:0] rot_right(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[0], x[27:1]};
            2'd2:    return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

endpackage

// File: rtl/des_decrypt_iter_if.sv
// Host-side command/result bundle of the DES decryption engine.
// SALT is present only when DES_DECRYPT_SALT_EN is defined.
interface des_decrypt_iter_if;
    logic        IN_VALID;
    logic        IN_READY;
    logic [63:0] KEY;
    logic [63:0] CT;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [63:0] PT;
    logic        BUSY;
`ifdef DES_DECRYPT_SALT_EN
    logic [11:0] SALT;
`endif

    modport master (
`ifdef DES_DECRYPT_SALT_EN
        output SALT,
`endif
        output IN_VALID, KEY, CT, OUT_READY,
        input  IN_READY, OUT_VALID, PT, BUSY
    );

    modport slave (
`ifdef DES_DECRYPT_SALT_EN
        input  SALT,
`endif
        input  IN_VALID, KEY, CT, OUT_READY,
        output IN_READY, OUT_VALID, PT, BUSY
    );
endinterface

// File: rtl/des_decrypt_iter_round.sv
// One combinational DES Feistel round plus the S-box cell it is built from.
// With DES_DECRYPT_SALT_EN the E output is salt-perturbed (crypt(3) style) before keying.
module des_sbox
    import des_pkg::*;
#(
    parameter int IDX = 0
) (
    input  logic [5:0] x_i,
    output logic [3:0] y_o
);
    assign y_o = sbox(IDX, x_i);
endmodule

module des_round
    import des_pkg::*;
(
    input  logic [HALF_W-1:0] l_i,
    input  logic [HALF_W-1:0] r_i,
    input  logic [SUBK_W-1:0] k_i,
`ifdef DES_DECRYPT_SALT_EN
    input  logic [11:0]       salt_i,
`endif
    output logic [HALF_W-1:0] l_o,
    output logic [HALF_W-1:0] r_o
);
    logic [SUBK_W-1:0] e_raw;
    logic [SUBK_W-1:0] e_mix;
    logic [SUBK_W-1:0] x;
    logic [HALF_W-1:0] s_out;

    assign e_raw = e_expand(r_i);

`ifdef DES_DECRYPT_SALT_EN
    // Salt bit k exchanges E positions k+1 and k+25.
    always_comb begin
        e_mix = e_raw;
        for (int k = 0; k < 12; k++) begin
            if (salt_i[k]) begin
                e_mix[47-k] = e_raw[23-k];
                e_mix[23-k] = e_raw[47-k];
            end
        end
    end
`else
    assign e_mix = e_raw;
`endif

    assign x = e_mix ^ k_i;

    for (genvar g = 0; g < 8; g++) begin : g_sbox
        des_sbox #(.IDX(g)) u_sbox (
            .x_i (x[47-6*g -: 6]),
            .y_o (s_out[31-4*g -: 4])
        );
    end

    assign l_o = r_i;
    assign r_o = l_i ^ p_perm(s_out);
endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES block decryptor: one Feistel round per clock, key schedule run backwards.
// Optional salt perturbation enabled by DES_DECRYPT_SALT_EN.
module des_decrypt_iter
    import des_pkg::*;
#(
    parameter int ROUNDS = 16
) (
    input  logic              CLK,
    input  logic              RST,
    des_decrypt_iter_if.slave bus
);
    localparam logic [3:0] LAST = 4'(ROUNDS - 1);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [HALF_W-1:0]  l_q, l_d, r_q, r_d;
    logic [CD_W-1:0]    c_q, c_d, d_q, d_d;
    logic [BLK_W-1:0]   pt_q, pt_d;
    logic               ov_q, ov_d;
    logic [HALF_W-1:0]  l_nx, r_nx;
    logic [SUBK_W-1:0]  subkey;
    logic [BLK_W-1:0]   ct_ip;
    logic [55:0]        key_pc1;
`ifdef DES_DECRYPT_SALT_EN
    logic [11:0]        salt_q, salt_d;
`endif

    assign subkey  = pc2_perm({c_q, d_q});
    assign ct_ip   = ip_perm(bus.CT);
    assign key_pc1 = pc1_perm(bus.KEY);

    des_round u_round (
        .l_i    (l_q),
        .r_i    (r_q),
        .k_i    (subkey),
`ifdef DES_DECRYPT_SALT_EN
        .salt_i (salt_q),
`endif
        .l_o    (l_nx),
        .r_o    (r_nx)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        l_d     = l_q;
        r_d     = r_q;
        c_d     = c_q;
        d_d     = d_q;
        pt_d    = pt_q;
        ov_d    = ov_q;
`ifdef DES_DECRYPT_SALT_EN
        salt_d  = salt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.IN_VALID) begin
                    l_d     = ct_ip[63:32];
                    r_d     = ct_ip[31:0];
                    c_d     = key_pc1[55:28];
                    d_d     = key_pc1[27:0];
                    cnt_d   = 4'd0;
                    state_d = ROUND;
`ifdef DES_DECRYPT_SALT_EN
                    salt_d  = bus.SALT;
`endif
                end
            end
            ROUND: begin
                l_d = l_nx;
                r_d = r_nx;
                c_d = rot_right(c_q, DEC_ROT[cnt_q]);
                d_d = rot_right(d_q, DEC_ROT[cnt_q]);
                // Final round: undo the last swap before the inverse IP.
                if (cnt_q == LAST) begin
                    pt_d    = fp_perm({r_nx, l_nx});
                    ov_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                if (bus.OUT_READY) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            l_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            pt_q    <= '0;
            ov_q    <= 1'b0;
`ifdef DES_DECRYPT_SALT_EN
            salt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            l_q     <= l_d;
            r_q     <= r_d;
            c_q     <= c_d;
            d_q     <= d_d;
            pt_q    <= pt_d;
            ov_q    <= ov_d;
`ifdef DES_DECRYPT_SALT_EN
            salt_q  <= salt_d;
`endif
        end
    end

    assign bus.IN_READY  = (state_q == IDLE);
    assign bus.BUSY      = (state_q != IDLE);
    assign bus.OUT_VALID = ov_q;
    assign bus.PT        = pt_q;
endmodule

// File: tb/tb_des_decrypt_iter.sv
// Bench for des_decrypt_iter: known answers, handshake corners, async reset mid-block and
// random blocks encrypted by a forward-DES reference model (DES_DECRYPT_SALT_EN adds salt).
module tb_des_decrypt_iter;
    import des_pkg::*;

    localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] KAT_CT  = 64'h85E813540F0AB405;
    localparam logic [63:0] KAT_PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] ZK_CT   = 64'h8CA64DE9C1B123A7;
    localparam int T_IP = 0, T_FP = 1, T_E = 2, T_P = 3, T_PC1 = 4, T_PC2 = 5;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [11:0] cur_salt = 12'h000;
    int          n_chk = 0;
    int          n_err = 0;

    des_decrypt_iter_if bus();
    des_decrypt_iter #(.ROUNDS(16)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- forward DES reference (standard encryption order) ----------------
    function automatic int tbl(input int sel, input int i);
        case (sel)
            T_IP:    return IP_T[i];
            T_FP:    return FP_T[i];
            T_E:     return E_T[i];
            T_P:     return P_T[i];
            T_PC1:   return PC1_T[i];
            default: return PC2_T[i];
        endcase
    endfunction

    function automatic logic [63:0] perm(input logic [63:0] x, input int in_w, input int sel,
                                         input int out_w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < out_w; i++) r[out_w-1-i] = x[in_w - tbl(sel, i)];
        return r;
    endfunction

    function automatic logic [3:0] sbox_ref(input int s, input logic [5:0] b);
        int row, col;
        logic [255:0] t;
        row = 2 * int'(b[5]) + int'(b[0]);
        col = int'(b[4:1]);
        t = SBOX_T[s];
        return 4'((t >> (4 * (63 - (row * 16 + col)))) & 256'hF);
    endfunction

    function automatic logic [63:0] des_encrypt(input logic [63:0] key, input logic [63:0] pt,
                                                input logic [11:0] salt);
        int          sh [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [63:0] lr;
        logic [31:0] l, r, s, f, t;
        logic [47:0] k, e, ex, x;
        cd = 56'(perm(key, 64, T_PC1, 56));
        c  = cd[55:28];
        d  = cd[27:0];
        lr = perm(pt, 64, T_IP, 64);
        l  = lr[63:32];
        r  = lr[31:0];
        for (int rnd = 0; rnd < 16; rnd++) begin
            c  = (c << sh[rnd]) | (c >> (28 - sh[rnd]));
            d  = (d << sh[rnd]) | (d >> (28 - sh[rnd]));
            k  = 48'(perm({8'd0, c, d}, 56, T_PC2, 48));
            e  = 48'(perm({32'd0, r}, 32, T_E, 48));
            ex = e;
            for (int b = 0; b < 12; b++)
                if (salt[b]) begin
                    ex[48-(b+1)]  = e[48-(b+25)];
                    ex[48-(b+25)] = e[48-(b+1)];
                end
            x = ex ^ k;
            s = '0;
            for (int j = 0; j < 8; j++) s = {s[27:0], sbox_ref(j, x[47-6*j -: 6])};
            f = 32'(perm({32'd0, s}, 32, T_P, 32));
            t = r;
            r = l ^ f;
            l = t;
        end
        return perm({r, l}, 64, T_FP, 64);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic send(input string tag, input logic [63:0] key, input logic [63:0] ct);
        int w = 0;
        while (!bus.IN_READY && w < 50) begin
            @(negedge CLK);
            w++;
        end
        check({tag, "_rdy"}, 64'(bus.IN_READY), 64'd1);
        bus.IN_VALID = 1'b1;
        bus.KEY      = key;
        bus.CT       = ct;
`ifdef DES_DECRYPT_SALT_EN
        bus.SALT     = cur_salt;
`endif
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        bus.KEY      = {$urandom, $urandom};
        bus.CT       = {$urandom, $urandom};
`ifdef DES_DECRYPT_SALT_EN
        bus.SALT     = 12'($urandom);
`endif
    endtask

    task automatic wait_out(input string tag, input logic [63:0] exp);
        int lat = 0;
        while (!bus.OUT_VALID && lat < 40) begin
            @(negedge CLK);
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'd16);
        check({tag, "_pt"}, bus.PT, exp);
    endtask

    task automatic run_block(input string tag, input logic [63:0] key, input logic [63:0] ct,
                             input logic [63:0] exp);
        send(tag, key, ct);
        wait_out(tag, exp);
        @(negedge CLK);
        check({tag, "_release"}, {62'd0, bus.OUT_VALID, bus.IN_READY}, 64'b01);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    initial begin
        logic [63:0] key, pt;
        bit          seen_ov;
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b1;
        bus.KEY       = '0;
        bus.CT        = '0;
`ifdef DES_DECRYPT_SALT_EN
        bus.SALT      = '0;
`endif
        repeat (3) @(negedge CLK);
        check("rst_outs", {61'd0, bus.OUT_VALID, bus.BUSY, bus.IN_READY}, 64'b001);
        check("rst_pt", bus.PT, 64'd0);
        RST = 1'b0;
        #1 check("rst_in_ready", 64'(bus.IN_READY), 64'd1);
        @(negedge CLK);

        check("model_kat", des_encrypt(KAT_KEY, KAT_PT, 12'h000), KAT_CT);
        run_block("kat", KAT_KEY, KAT_CT, KAT_PT);
        run_block("zero_key", 64'd0, ZK_CT, 64'd0);
        run_block("parity", KAT_KEY ^ 64'h0101010101010101, KAT_CT, KAT_PT);

        // Backpressure; a second block is offered throughout DONE and must wait.
        bus.OUT_READY = 1'b0;
        send("bp", KAT_KEY, KAT_CT);
        wait_out("bp", KAT_PT);
        bus.IN_VALID = 1'b1;
        bus.KEY      = 64'd0;
        bus.CT       = ZK_CT;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("bp_hold_pt", bus.PT, KAT_PT);
            check("bp_hold_ctl", {61'd0, bus.OUT_VALID, bus.IN_READY, bus.BUSY}, 64'b101);
        end
        bus.OUT_READY = 1'b1;
        @(negedge CLK);
        check("bp_idle", {61'd0, bus.OUT_VALID, bus.IN_READY, bus.BUSY}, 64'b010);
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        bus.KEY      = {$urandom, $urandom};
        check("bp_second_taken", 64'(bus.BUSY), 64'd1);
        wait_out("bp_second", 64'd0);
        @(negedge CLK);

        // Asynchronous reset in the middle of a block.
        send("mid", KAT_KEY, KAT_CT);
        repeat (7) @(negedge CLK);
        #2 RST = 1'b1;
        #1 check("mid_rst_ctl", {61'd0, bus.OUT_VALID, bus.IN_READY, bus.BUSY}, 64'b010);
        check("mid_rst_pt", bus.PT, 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        seen_ov = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (bus.OUT_VALID || bus.BUSY) seen_ov = 1'b1;
        end
        check("mid_no_emit", 64'(seen_ov), 64'd0);
        run_block("mid_after", KAT_KEY, KAT_CT, KAT_PT);

`ifdef DES_DECRYPT_SALT_EN
        cur_salt = 12'h000;
        run_block("salt0", KAT_KEY, KAT_CT, KAT_PT);
        cur_salt = 12'hABC;
        run_block("saltABC", KAT_KEY, des_encrypt(KAT_KEY, KAT_PT, cur_salt), KAT_PT);
`endif

        for (int n = 0; n < 12; n++) begin
            key = {$urandom, $urandom};
            pt  = {$urandom, $urandom};
`ifdef DES_DECRYPT_SALT_EN
            cur_salt = 12'($urandom);
`endif
            run_block("rand", key, des_encrypt(key, pt, cur_salt), pt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/des_decrypt_iter.md
Name: des_decrypt_iter

Overview:
- Iterative single-block DES decryption engine: one Feistel round per clock, 16 rounds per block.
- Decryption counterpart to the existing forward DES datapath. It reuses the shared S-box modules S1–S8 and runs the key schedule in reverse, using right rotations.
- Sits between the host command FIFO (supplies key and ciphertext) and the result checker / readback path.

Parameters:
- ROUNDS, 16, number of Feistel rounds. Fixed at 16 for DES; exposed only for bench shortening.

Ports:
- CLK  in  1  single clock, rising edge
- RST  in  1  asynchronous, active-high reset
- IN_VALID  in  1  KEY/CT valid
- IN_READY  out  1  engine can accept a block
- KEY  in  64  DES key, FIPS-46 bit 1 = KEY[63]; parity bits (bit 8 of each byte) ignored
- CT  in  64  ciphertext block, bit 1 = CT[63]
- OUT_VALID  out  1  PT valid
- OUT_READY  in  1  downstream accepts PT
- PT  out  64  plaintext result
- BUSY  out  1  high in ROUND or DONE

Behaviour:
- Reset (async, any state, mid-block included):
  - state=IDLE, round counter=0, L/R/C/D registers=0, PT=0, OUT_VALID=0, BUSY=0.
  - IN_READY=1 once RST deasserts.
  - An in-flight block is discarded and never emitted.
- States: IDLE, ROUND, DONE.
- IDLE:
  - IN_READY=1.
  - On IN_VALID&IN_READY: latch IP(CT) into L0/R0 and PC1(KEY) into C/D; counter:=0; go to ROUND.
  - IN_VALID while not ready is ignored; CT/KEY need not be held.
- ROUND:
  - Each cycle: L'=R, R'=L xor f(R,K), with f = P(S1..S8(E(R) xor K)) and K = PC2(C,D) computed from the current C/D.
  - Key order: the first round uses K16 = PC2(C0,D0). No pre-shift is applied, because the total rotation is 28 = identity.
  - After each round, C and D each rotate right by the schedule for the next round: 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (rounds 2..16).
  - Counter 4 bits; after the round where counter=ROUNDS-1: PT := FP(R16||L16) (swap before FP), OUT_VALID:=1, go to DONE.
  - The counter does not wrap into a new block.
- DONE:
  - PT and OUT_VALID are held stable until OUT_READY.
  - On OUT_VALID&OUT_READY: OUT_VALID:=0, go to IDLE.
  - No same-cycle acceptance of a new block (one-cycle bubble).
- Latency: handshake accepted at edge t → OUT_VALID high after edge t+16 (16 ROUND cycles); throughput 1 block / 18 cycles with OUT_READY=1.
- IN_READY = (state==IDLE); BUSY = (state!=IDLE); both combinational from the state register.
- OUT_READY in IDLE or ROUND: ignored.

Optional Feature:
- Macro: DES_DECRYPT_SALT_EN. With it, a 12-bit SALT input is added.
- SALT is latched alongside KEY.
- In every round, for each salt bit k=0..11 that is set, E-output positions k+1 and k+25 (FIPS numbering) are swapped before the XOR with the subkey. This is the crypt(3) salt perturbation, inverted by the reversed key order.
- Without the macro: no SALT port; E output is used unmodified. Otherwise identical timing.

Decomposition:
- Package des_pkg holds:
  - IP, FP, E, P, PC1 and PC2 permutation tables as constant index arrays
  - the decryption rotation schedule constant
  - the state enum (IDLE/ROUND/DONE)
  - width constants: block 64, half 32, subkey 48, C/D 28
- One sub-module: des_round.
  - Inputs: L, R, subkey (and salt when enabled). Outputs: L', R'.
  - Purely combinational; instantiates S1–S8.
- des_decrypt_iter owns the FSM, counter, key-schedule registers and handshake.

Test Plan:
- Known answer: KEY=133457799BBCDFF1, CT=85E813540F0AB405 → PT=0123456789ABCDEF, OUT_VALID exactly 16 cycles after the input handshake.
- Zero key: KEY=0000000000000000, CT=8CA64DE9C1B123A7 → PT=0000000000000000.
- Backpressure: OUT_READY=0 for 10 cycles after OUT_VALID → PT stable, IN_READY=0, BUSY=1; OUT_READY=1 → IDLE next cycle; second block accepted only after that.
- Reset mid-round: assert RST at round 7 of the KAT block → OUT_VALID stays 0, state IDLE; the next KAT block produces the correct PT with no residue.
- Parity independence: KEY=133457799BBCDFF1 xor 0101010101010101 → same PT=0123456789ABCDEF.
- DES_DECRYPT_SALT_EN:
  - SALT=000 → identical to the KAT.
  - SALT=ABC, with CT produced by the golden salted-encrypt model for KEY=133457799BBCDFF1, PT=0123456789ABCDEF → PT recovered.
